// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder behind the load/store buffer.
// Requests are single-cycle strobes. Each one is resolved in the cycle it is
// accepted: stores write the array and loads sample it in that cycle. The
// response then travels down a LATENCY-stage shift pipeline.
//
// Optional feature, selected with the macro DMEM_MISS_MODEL_EN:
//   A 4-line direct-mapped tag store with a two-state FSM. A miss is held
//   for LATENCY+MISS_PENALTY cycles, and req_ready is low while it waits.
//   When the macro is undefined, req_ready is tied to 1 and miss is always 0.
//
// Miss FSM (only when DMEM_MISS_MODEL_EN is defined):
//   state       | meaning
//   S_IDLE      | accepting requests, req_ready=1
//   S_MISS_WAIT | one miss outstanding, req_ready=0, older hits drain
module dmem_responder #(
  parameter int WORDS        = 256,
  parameter int LATENCY      = 2,
  parameter int MISS_PENALTY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_addr,
  input  logic [63:0] write_data,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_is_store,
  output logic [63:0] read_data,
  output logic        miss,
  output logic        err
);

  localparam int AW = $clog2(WORDS);

  logic [63:0]   mem_q [WORDS];
  logic [AW-1:0] idx;
  logic          bad;
  logic          accept;
  logic          take_miss;
  logic          miss_fire;
  logic          mh_store;
  logic [63:0]   mh_data;
  logic [63:0]   ld_data;

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] ps;
  logic [LATENCY-1:0] pe;
  logic [LATENCY-1:0] pm;
  logic [63:0]        pd [LATENCY];

  assign idx     = mem_addr[AW+2:3];
  assign bad     = (mem_addr[2:0] != 3'b000) || (mem_addr[63:AW+3] != '0);
  assign accept  = (mem_read ^ mem_write) && req_ready;
  // Stores and errored requests carry zero data, so the output mux needs no extra masking.
  assign ld_data = (bad || mem_write) ? 64'd0 : mem_q[idx];

  // Array write at acceptance; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept && mem_write && !bad) begin
      mem_q[idx] <= write_data;
    end
  end

  // Response shift pipeline; hits enter here, misses use the holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      ps <= '0;
      pe <= '0;
      pm <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= 64'd0;
    end else begin
      pv[0] <= accept && !take_miss;
      ps[0] <= mem_write;
      pe[0] <= bad;
      pm[0] <= 1'b0;
      pd[0] <= ld_data;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pe[i] <= pe[i-1];
        pm[i] <= pm[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

`ifdef DMEM_MISS_MODEL_EN
  localparam int CW = $clog2(LATENCY + MISS_PENALTY + 1);

  typedef enum logic {S_IDLE, S_MISS_WAIT} state_t;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   tag_v;
  logic [55:0]  tag_q [4];
  logic [1:0]   line;
  logic         lookup_miss;
  logic [CW-1:0] cnt_q;

  assign line        = mem_addr[7:6];
  assign lookup_miss = !tag_v[line] || (tag_q[line] != mem_addr[63:8]);
  assign take_miss   = accept && !bad && lookup_miss;

  // Tag store: line allocated when the miss is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < 4; i++) tag_q[i] <= '0;
    end else if (take_miss) begin
      tag_v[line] <= 1'b1;
      tag_q[line] <= mem_addr[63:8];
    end
  end

  // Miss holding register with down-counter to the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mh_store <= 1'b0;
      mh_data  <= 64'd0;
    end else if (take_miss) begin
      cnt_q    <= CW'(LATENCY + MISS_PENALTY - 1);
      mh_store <= mem_write;
      mh_data  <= ld_data;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (take_miss) state_d = S_MISS_WAIT;
      S_MISS_WAIT: if (miss_fire) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    miss_fire = (state_q == S_MISS_WAIT) && (cnt_q == '0);
  end
`else
  logic unused_miss_penalty;

  // The miss penalty only matters when the tag model is built in
  assign unused_miss_penalty = (MISS_PENALTY != 0);
  assign req_ready = 1'b1;
  assign take_miss = 1'b0;
  assign miss_fire = 1'b0;
  assign mh_store  = 1'b0;
  assign mh_data   = 64'd0;
`endif

  // Response mux; hits and a miss never land in the same cycle because the
  // miss blocks new requests and always completes after the older hits
  always_comb begin
    resp_valid    = 1'b0;
    resp_is_store = 1'b0;
    read_data     = 64'd0;
    miss          = 1'b0;
    err           = 1'b0;
    if (pv[LATENCY-1]) begin
      resp_valid    = 1'b1;
      resp_is_store = ps[LATENCY-1];
      read_data     = pd[LATENCY-1];
      miss          = pm[LATENCY-1];
      err           = pe[LATENCY-1];
    end else if (miss_fire) begin
      resp_valid    = 1'b1;
      resp_is_store = mh_store;
      read_data     = mh_data;
      miss          = 1'b1;
    end
  end

endmodule
